// File: rtl/waveform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_pkg
//  Description : Shared types and constants for the DAC waveform sequencer:
//                FSM state encoding, playback mode codes, default DAC prefix.
//  Revision    : 1.0 - initial release
// ============================================================================
package waveform_pkg;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Playback mode codes; code 3 is reserved and plays as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_LOOP    = 2'd1;
    localparam logic [1:0] MODE_CONT    = 2'd2;

    // Command bits prepended to every sample sent to the DAC
    localparam logic [3:0] DAC_PREFIX_DEFAULT = 4'b0001;

endpackage : waveform_pkg
`default_nettype wire

// File: rtl/waveform_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_sample_ram
//  Description : Simple dual-port sample buffer. One synchronous write port
//                and one synchronous read port; read data appears one cycle
//                after the address is presented with i_rd_en high and then
//                holds until the next enabled read.
//  Revision    : 1.0 - initial release
// ============================================================================
module waveform_sample_ram #(
    parameter int WORD_WID = 20,
    parameter int ADDR_WID = 11
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [ADDR_WID-1:0] i_wr_addr,
    input  logic [WORD_WID-1:0] i_wr_data,
    input  logic                i_rd_en,
    input  logic [ADDR_WID-1:0] i_rd_addr,
    output logic [WORD_WID-1:0] o_rd_data
);

    localparam int C_DEPTH = 2 ** ADDR_WID;

    logic [WORD_WID-1:0] r_mem [0:C_DEPTH-1];
    logic [WORD_WID-1:0] r_rd_data;

    // Write port: store the sample on the clock edge
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered read, held between enabled reads
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : waveform_sample_ram
`default_nettype wire

// File: rtl/waveform_seq.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_seq
//  Description : Multi-mode DAC waveform sequencer. Plays an inclusive index
//                window of a local sample buffer to an external SPI master
//                through an arm/finished handshake, with a programmable idle
//                delay before each sample. Modes: one-shot, N loops,
//                continuous.
//  Revision    : 1.0 - initial release
// ============================================================================
module waveform_seq
    import waveform_pkg::*;
#(
    parameter int                    WORD_WID   = 20,
    parameter int                    ADDR_WID   = 11,
    parameter int                    PREFIX_WID = 4,
    parameter logic [PREFIX_WID-1:0] DAC_PREFIX = DAC_PREFIX_DEFAULT,
    parameter int                    DAC_WID    = 24,   // PREFIX_WID + WORD_WID
    parameter int                    TIMER_WID  = 32,
    parameter int                    LOOP_WID   = 16
) (
    input  logic                 clk,
    input  logic                 rst_L,
    // Host buffer write port
    input  logic                 wr_en,
    input  logic [ADDR_WID-1:0]  wr_addr,
    input  logic [WORD_WID-1:0]  wr_data,
    // Playback control
    input  logic                 arm,
    input  logic [1:0]           mode,
    input  logic [LOOP_WID-1:0]  loop_count,
    input  logic [ADDR_WID-1:0]  first_idx,
    input  logic [ADDR_WID-1:0]  last_idx,
    input  logic [TIMER_WID-1:0] time_to_wait,
    // Status
    output logic                 busy,
    output logic                 finished,
    output logic                 err_cfg,
    output logic [ADDR_WID-1:0]  cur_idx,
    output logic [LOOP_WID-1:0]  loops_done,
    // SPI master handshake
    output logic                 dac_arm,
    output logic [DAC_WID-1:0]   dac_out,
    input  logic                 dac_finished
);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [TIMER_WID-1:0] r_timer;
    logic [ADDR_WID-1:0]  r_idx;
    logic [LOOP_WID-1:0]  r_loops_done;
    logic [1:0]           r_mode;
    logic [LOOP_WID-1:0]  r_loop_count;
    logic [ADDR_WID-1:0]  r_first;
    logic [ADDR_WID-1:0]  r_last;

    logic                 r_busy;
    logic                 r_finished;
    logic                 r_err_cfg;
    logic [ADDR_WID-1:0]  r_cur_idx;
    logic                 r_dac_arm;
    logic [DAC_WID-1:0]   r_dac_out;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [WORD_WID-1:0]  w_rd_data;
    logic                 w_rd_en;
    logic                 w_wr_en;
    logic [LOOP_WID-1:0]  w_loops_inc;
    logic [LOOP_WID-1:0]  w_loop_target;

    // Host writes are locked out during playback so the read port never
    // collides with a write to the same address.
    assign w_wr_en = wr_en & ~r_busy;

    // The buffer is only read in FETCH; the result is consumed in LOAD and
    // stays stable if LOAD has to wait for the master to go idle.
    assign w_rd_en = (r_state == ST_FETCH);

    // Pass counter saturates instead of wrapping in continuous mode
    assign w_loops_inc = (r_loops_done == {LOOP_WID{1'b1}}) ? r_loops_done
                                                            : r_loops_done + LOOP_WID'(1);

    // A loop count of zero is played as a single pass
    assign w_loop_target = (r_loop_count == '0) ? LOOP_WID'(1) : r_loop_count;

    // ------------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------------
    waveform_sample_ram #(
        .WORD_WID (WORD_WID),
        .ADDR_WID (ADDR_WID)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------------
    // Playback FSM with registered status and handshake outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_idx        <= '0;
            r_loops_done <= '0;
            r_mode       <= MODE_ONESHOT;
            r_loop_count <= '0;
            r_first      <= '0;
            r_last       <= '0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_cur_idx    <= '0;
            r_dac_arm    <= 1'b0;
            r_dac_out    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_finished <= 1'b0;
                    if (arm) begin
                        if (last_idx >= first_idx) begin
                            // Latch the window and mode for the whole run
                            r_state      <= ST_WAIT;
                            r_busy       <= 1'b1;
                            r_timer      <= time_to_wait;
                            r_idx        <= first_idx;
                            r_loops_done <= '0;
                            r_err_cfg    <= 1'b0;
                            r_mode       <= mode;
                            r_loop_count <= loop_count;
                            r_first      <= first_idx;
                            r_last       <= last_idx;
                        end else begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!arm) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_timer <= r_timer - TIMER_WID'(1);
                    end
                end

                ST_FETCH: begin
                    r_state <= ST_LOAD;
                end

                ST_LOAD: begin
                    r_dac_out <= {DAC_PREFIX, w_rd_data};
                    r_cur_idx <= r_idx;
                    // Only start a frame once the master has dropped finished
                    if (!dac_finished) begin
                        r_dac_arm <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // A frame in flight always completes before anything else
                    if (dac_finished) begin
                        r_dac_arm <= 1'b0;
                        if (!arm) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_idx != r_last) begin
                            r_idx   <= r_idx + ADDR_WID'(1);
                            r_timer <= time_to_wait;
                            r_state <= ST_WAIT;
                        end else begin
                            // End of pass: rewind to the window start
                            r_loops_done <= w_loops_inc;
                            r_idx        <= r_first;
                            r_timer      <= time_to_wait;
                            case (r_mode)
                                MODE_CONT: begin
                                    r_state <= ST_WAIT;
                                end
                                MODE_LOOP: begin
                                    if (w_loops_inc == w_loop_target) begin
                                        r_state    <= ST_DONE;
                                        r_busy     <= 1'b0;
                                        r_finished <= 1'b1;
                                    end else begin
                                        r_state <= ST_WAIT;
                                    end
                                end
                                default: begin
                                    r_state    <= ST_DONE;
                                    r_busy     <= 1'b0;
                                    r_finished <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                ST_DONE: begin
                    if (!arm) begin
                        r_state    <= ST_IDLE;
                        r_finished <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_dac_arm <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy       = r_busy;
    assign finished   = r_finished;
    assign err_cfg    = r_err_cfg;
    assign cur_idx    = r_cur_idx;
    assign loops_done = r_loops_done;
    assign dac_arm    = r_dac_arm;
    assign dac_out    = r_dac_out;

endmodule : waveform_seq
`default_nettype wire

// File: tb/tb_waveform_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_waveform_seq
//  Description : Directed self-checking bench for waveform_seq. Includes a
//                small SPI master model that raises finished 10 cycles after
//                arm and drops it once arm is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_waveform_seq;

    localparam int WORD_WID  = 20;
    localparam int ADDR_WID  = 11;
    localparam int DAC_WID   = 24;
    localparam int TIMER_WID = 32;
    localparam int LOOP_WID  = 16;

    logic                 clk = 1'b0;
    logic                 rst_L = 1'b0;
    logic                 wr_en = 1'b0;
    logic [ADDR_WID-1:0]  wr_addr = '0;
    logic [WORD_WID-1:0]  wr_data = '0;
    logic                 arm = 1'b0;
    logic [1:0]           mode = '0;
    logic [LOOP_WID-1:0]  loop_count = '0;
    logic [ADDR_WID-1:0]  first_idx = '0;
    logic [ADDR_WID-1:0]  last_idx = '0;
    logic [TIMER_WID-1:0] time_to_wait = '0;
    logic                 busy;
    logic                 finished;
    logic                 err_cfg;
    logic [ADDR_WID-1:0]  cur_idx;
    logic [LOOP_WID-1:0]  loops_done;
    logic                 dac_arm;
    logic [DAC_WID-1:0]   dac_out;
    logic                 dac_finished = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    waveform_seq dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .arm          (arm),
        .mode         (mode),
        .loop_count   (loop_count),
        .first_idx    (first_idx),
        .last_idx     (last_idx),
        .time_to_wait (time_to_wait),
        .busy         (busy),
        .finished     (finished),
        .err_cfg      (err_cfg),
        .cur_idx      (cur_idx),
        .loops_done   (loops_done),
        .dac_arm      (dac_arm),
        .dac_out      (dac_out),
        .dac_finished (dac_finished)
    );

    always #5 clk = ~clk;

    // SPI master model: finished rises 10 cycles after arm, falls after arm drops
    int spi_cnt = 0;
    always @(posedge clk) begin
        if (!dac_arm) begin
            spi_cnt      <= 0;
            dac_finished <= 1'b0;
        end else if (spi_cnt == 9) begin
            dac_finished <= 1'b1;
        end else begin
            spi_cnt <= spi_cnt + 1;
        end
    end

    // Monitor: record each DAC word at the arm rising edge and the number of
    // busy cycles with dac_arm low that preceded it
    logic [DAC_WID-1:0] q_out[$];
    int                 q_gap[$];
    logic               m_prev_arm = 1'b0;
    int                 m_gap = 0;
    always @(negedge clk) begin
        if (dac_arm && !m_prev_arm) begin
            q_out.push_back(dac_out);
            q_gap.push_back(m_gap);
        end
        if (busy && !dac_arm) m_gap = m_gap + 1;
        else                  m_gap = 0;
        m_prev_arm = dac_arm;
    end

    task automatic write_word(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_WID'(addr);
        wr_data = WORD_WID'(data);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_finished(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (finished) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic disarm_to_idle();
        @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_L = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, finished, err_cfg, dac_arm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/fin/err/arm=%b required 0000",
                     {busy, finished, err_cfg, dac_arm});
        end
        rst_L = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cur_idx !== '0 || loops_done !== '0 || dac_out !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got cur_idx=%0d loops=%0d dac_out=%h required 0 0 0",
                     cur_idx, loops_done, dac_out);
        end
        for (int i = 0; i < 8; i++) write_word(i, 'h10 + i);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_oneshot();
        int base;
        bit ok;
        logic [DAC_WID-1:0] exp_w;
        base = q_out.size();
        @(negedge clk);
        mode = 2'd0; first_idx = 2; last_idx = 5; time_to_wait = 3; arm = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_busy: got %b required 1", busy);
        end
        wait_finished(400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL oneshot_timeout: finished got 0 required 1");
        end
        n_checks++;
        if (q_out.size() - base !== 4) begin
            n_fail++;
            $display("FAIL oneshot_count: got %0d words required 4", q_out.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_out.size(); k++) begin
            exp_w = 24'h100012 + DAC_WID'(k);
            n_checks++;
            if (q_out[base + k] !== exp_w) begin
                n_fail++;
                $display("FAIL oneshot_word%0d: got %h required %h", k, q_out[base + k], exp_w);
            end
            n_checks++;
            if (q_gap[base + k] < 6) begin
                n_fail++;
                $display("FAIL oneshot_gap%0d: got %0d idle cycles required at least 6",
                         k, q_gap[base + k]);
            end
        end
        n_checks++;
        if (cur_idx !== 11'd5 || loops_done !== 16'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_status: got cur_idx=%0d loops=%0d busy=%b required 5 1 0",
                     cur_idx, loops_done, busy);
        end
        disarm_to_idle();
        n_checks++;
        if (finished !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_clear: finished got %b required 0", finished);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_loop();
        int base;
        bit ok;
        logic [DAC_WID-1:0] exp_w;
        base = q_out.size();
        @(negedge clk);
        mode = 2'd1; loop_count = 3; first_idx = 0; last_idx = 1; time_to_wait = 1; arm = 1'b1;
        wait_finished(600, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loop_timeout: finished got 0 required 1");
        end
        n_checks++;
        if (q_out.size() - base !== 6) begin
            n_fail++;
            $display("FAIL loop_count: got %0d words required 6", q_out.size() - base);
        end
        for (int k = 0; k < 6 && base + k < q_out.size(); k++) begin
            exp_w = 24'h100010 + DAC_WID'(k % 2);
            n_checks++;
            if (q_out[base + k] !== exp_w) begin
                n_fail++;
                $display("FAIL loop_word%0d: got %h required %h", k, q_out[base + k], exp_w);
            end
        end
        n_checks++;
        if (loops_done !== 16'd3) begin
            n_fail++;
            $display("FAIL loop_passes: got %0d required 3", loops_done);
        end
        @(negedge clk);
        arm = 1'b0;
        n_checks++;
        if (finished !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_fin_hold: got %b required 1", finished);
        end
        @(negedge clk);
        n_checks++;
        if (finished !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_fin_clear: got %b required 0", finished);
        end
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_continuous_abort();
        int  rises;
        bit  saw_fin;
        bit  prev;
        bit  ok;
        rises = 0; saw_fin = 1'b0; prev = 1'b0;
        @(negedge clk);
        mode = 2'd2; first_idx = 4; last_idx = 4; time_to_wait = 0; arm = 1'b1;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(negedge clk);
            if (finished) saw_fin = 1'b1;
            if (dac_arm && !prev) begin
                rises++;
                n_checks++;
                if (dac_out !== 24'h100014) begin
                    n_fail++;
                    $display("FAIL cont_word%0d: got %h required 100014", rises, dac_out);
                end
            end
            prev = dac_arm;
        end
        n_checks++;
        if (rises !== 3) begin
            n_fail++;
            $display("FAIL cont_timeout: got %0d frames required 3", rises);
        end
        n_checks++;
        if (loops_done !== 16'd2 || saw_fin !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_status: got loops=%0d finished_seen=%b required 2 0",
                     loops_done, saw_fin);
        end
        // Abort during the third frame
        arm = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dac_arm !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_hold: dac_arm got %b required 1", dac_arm);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dac_arm) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok || busy !== 1'b0 || finished !== 1'b0 || loops_done !== 16'd2) begin
            n_fail++;
            $display("FAIL abort_idle: got released=%b busy=%b fin=%b loops=%0d required 1 0 0 2",
                     ok, busy, finished, loops_done);
        end
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bad_config();
        int base;
        bit ok;
        logic [DAC_WID-1:0] exp_w;
        base = q_out.size();
        @(negedge clk);
        mode = 2'd0; first_idx = 6; last_idx = 3; time_to_wait = 2; arm = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0 || q_out.size() !== base) begin
            n_fail++;
            $display("FAIL badcfg_reject: got err=%b busy=%b frames=%0d required 1 0 0",
                     err_cfg, busy, q_out.size() - base);
        end
        first_idx = 3; last_idx = 6;
        @(negedge clk);
        n_checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL badcfg_recover: got err=%b busy=%b required 0 1", err_cfg, busy);
        end
        wait_finished(400, ok);
        n_checks++;
        if (!ok || q_out.size() - base !== 4) begin
            n_fail++;
            $display("FAIL badcfg_run: got finished=%b frames=%0d required 1 4",
                     ok, q_out.size() - base);
        end
        for (int k = 0; k < 4 && base + k < q_out.size(); k++) begin
            exp_w = 24'h100013 + DAC_WID'(k);
            n_checks++;
            if (q_out[base + k] !== exp_w) begin
                n_fail++;
                $display("FAIL badcfg_word%0d: got %h required %h", k, q_out[base + k], exp_w);
            end
        end
        disarm_to_idle();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_in_send();
        int base;
        bit ok;
        @(negedge clk);
        mode = 2'd0; first_idx = 0; last_idx = 0; time_to_wait = 0; arm = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dac_arm) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstsend_start: dac_arm got 0 required 1");
        end
        // Attempted overwrite while busy must be ignored
        wr_en = 1'b1; wr_addr = 0; wr_data = 20'hABCDE;
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst_L = 1'b0;
        #1;
        n_checks++;
        if ({dac_arm, busy, finished} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstsend_async: got arm/busy/fin=%b required 000",
                     {dac_arm, busy, finished});
        end
        arm = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || loops_done !== '0 || cur_idx !== '0) begin
            n_fail++;
            $display("FAIL rstsend_idle: got busy=%b loops=%0d cur_idx=%0d required 0 0 0",
                     busy, loops_done, cur_idx);
        end
        base = q_out.size();
        arm = 1'b1;
        wait_finished(200, ok);
        n_checks++;
        if (!ok || q_out.size() - base !== 1) begin
            n_fail++;
            $display("FAIL replay_run: got finished=%b frames=%0d required 1 1",
                     ok, q_out.size() - base);
        end else begin
            n_checks++;
            if (q_out[base] !== 24'h100010) begin
                n_fail++;
                $display("FAIL replay_word: got %h required 100010", q_out[base]);
            end
        end
        disarm_to_idle();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_continuous_abort();
        test_bad_config();
        test_reset_in_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_waveform_seq
`default_nettype wire
